// File: rtl/soc_bus_pkg.sv
// Shared bus definitions for the SoC Wishbone fabric: transfer-width encodings,
// responder state encoding and the boot RAM window base.
package soc_bus_pkg;

    localparam logic [31:0] BOOT_BASE = 32'hb000_0000;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_RSVD = 2'b10,
        WIDTH_WORD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } resp_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        width_e      width;
    } bus_req_t;

endpackage

// File: rtl/wb_lane_mux.sv
// Little-endian byte-lane steering between right-aligned bus data and a 32-bit
// RAM word: write byte-enables, replicated write data, aligned read data.
module wb_lane_mux
    import soc_bus_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  width_e      width,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        rdata      = 32'h0;
        misalign   = 1'b0;
        shifted    = rword >> {addr_lo, 3'b000};
        case (width)
            WIDTH_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata      = {24'h0, shifted[7:0]};
            end
            WIDTH_HALF: begin
                misalign   = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata      = {16'h0, shifted[15:0]};
            end
            WIDTH_WORD: begin
                misalign   = (addr_lo != 2'b00);
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata      = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone single-beat responder for the boot/stack RAM: wait-state FSM,
// window decode, fault reporting and the byte-lane RAM array.
module wb_ram_responder
    import soc_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BOOT_BASE,
    parameter int          ADDR_BITS   = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [1:0]  i_data_width,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stl,
    output logic        o_exception
);

    localparam int         WORDS     = 2 ** (ADDR_BITS - 2);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    resp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    bus_req_t    req_q, req_d;
    logic        ack_q, ack_d;
    logic        stl_q, stl_d;
    logic        exc_q, exc_d;
    logic [31:0] data_q, data_d;

    bus_req_t    in_req, cur_req;
    logic        idle, accept, commit, fault, in_range, mem_we;
    logic [31:0] offset, rword, rdata, wdata_lane;
    logic [3:0]  be;
    logic        misalign;
    logic [ADDR_BITS-3:0] word_idx;

    logic [31:0] mem [WORDS];

    // With zero wait states the transfer completes on its acceptance edge, so
    // decode and lane steering work on the live bus request while idle.
    always_comb begin
        in_req.addr  = i_wb_addr;
        in_req.data  = i_wb_data;
        in_req.we    = i_wb_we;
        in_req.width = width_e'(i_data_width);
        idle         = (state_q == ST_IDLE);
        accept       = idle && i_wb_cyc && i_wb_stb && !stl_q;
        cur_req      = idle ? in_req : req_q;
        offset       = cur_req.addr - BASE_ADDR;
        in_range     = (offset[31:ADDR_BITS] == '0);
        word_idx     = offset[ADDR_BITS-1:2];
        rword        = mem[word_idx];
    end

    wb_lane_mux u_lane_mux (
        .addr_lo    (offset[1:0]),
        .width      (cur_req.width),
        .wdata      (cur_req.data),
        .rword      (rword),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata      (rdata),
        .misalign   (misalign)
    );

    assign fault = !in_range || (cur_req.width == WIDTH_RSVD) || misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ack_d   = 1'b0;
        exc_d   = 1'b0;
        data_d  = data_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d = in_req;
                    if (WAIT_LOAD == 4'd0) begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (commit) begin
            ack_d  = 1'b1;
            exc_d  = fault;
            data_d = (fault || cur_req.we) ? 32'h0 : rdata;
        end
        stl_d = (state_d != ST_IDLE);
    end

    // Reset is folded in so a strobe seen while reset is held can never write.
    assign mem_we = commit && cur_req.we && !fault && reset;

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            stl_q   <= 1'b0;
            exc_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            stl_q   <= stl_d;
            exc_q   <= exc_d;
            data_q  <= data_d;
        end
    end

    // NOTE: the RAM array has no reset; clearing it would turn the storage into
    // 64 KiB of resettable flops, and boot code never relies on its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    assign o_wb_data   = data_q;
    assign o_wb_ack    = ack_q;
    assign o_wb_stl    = stl_q;
    assign o_exception = exc_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: one instance with one wait state and one
// with none, exercised through a shared bus driver.
module tb_wb_ram_responder;

    logic        clk;
    logic        reset;
    logic        cyc, stb, we;
    logic [31:0] addr, wdata;
    logic [1:0]  width;
    logic        sel_q;

    logic [31:0] dat1, dat0, dat_s;
    logic        ack1, ack0, ack_s;
    logic        stl1, stl0, stl_s;
    logic        exc1, exc0, exc_s;

    int n_checks;
    int n_fail;

    wb_ram_responder #(.WAIT_STATES(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_wb_cyc     (cyc & ~sel_q),
        .i_wb_stb     (stb & ~sel_q),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .i_wb_data    (wdata),
        .i_data_width (width),
        .o_wb_data    (dat1),
        .o_wb_ack     (ack1),
        .o_wb_stl     (stl1),
        .o_exception  (exc1)
    );

    wb_ram_responder #(.WAIT_STATES(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .i_wb_cyc     (cyc & sel_q),
        .i_wb_stb     (stb & sel_q),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .i_wb_data    (wdata),
        .i_data_width (width),
        .o_wb_data    (dat0),
        .o_wb_ack     (ack0),
        .o_wb_stl     (stl0),
        .o_exception  (exc0)
    );

    assign dat_s = sel_q ? dat0 : dat1;
    assign ack_s = sel_q ? ack0 : ack1;
    assign stl_s = sel_q ? stl0 : stl1;
    assign exc_s = sel_q ? exc0 : exc1;

    always #5 clk = ~clk;

    // One complete transfer; returns negedges from acceptance to ack (20 = none).
    task automatic xfer(input logic s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] wd,
                        output int lat, output logic [31:0] rd, output logic ex,
                        output logic stl_ok, output logic stl_after);
        @(negedge clk);
        sel_q = s; cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; width = wd;
        @(negedge clk);
        stb = 1'b0;
        lat = 1;
        stl_ok = 1'b1;
        while (!ack_s && lat < 20) begin
            if (!stl_s) stl_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!stl_s) stl_ok = 1'b0;
        rd = dat_s;
        ex = exc_s;
        @(negedge clk);
        stl_after = stl_s;
        cyc = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack1); end
        n_checks++; if (stl1 !== 1'b0) begin n_fail++; $display("FAIL rst_stl: got %b want 0", stl1); end
        n_checks++; if (exc1 !== 1'b0) begin n_fail++; $display("FAIL rst_exc: got %b want 0", exc1); end
        n_checks++; if (dat1 !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", dat1); end
        n_checks++; if ({ack0, stl0, exc0} !== 3'b000) begin n_fail++; $display("FAIL rst_dut0: got %b want 000", {ack0, stl0, exc0}); end
        reset = 1'b1;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic ex, so, sa;
        xfer(1'b0, 1'b1, 32'hb000_0010, 32'hdead_beef, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL word_wr_lat: got %0d want 2", lat); end
        n_checks++; if (so !== 1'b1) begin n_fail++; $display("FAIL word_wr_stall: got %b want 1", so); end
        n_checks++; if (sa !== 1'b0) begin n_fail++; $display("FAIL word_wr_stall_drop: got %b want 0", sa); end
        n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL word_wr_exc: got %b want 0", ex); end
        xfer(1'b0, 1'b0, 32'hb000_0010, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL word_rd_lat: got %0d want 2", lat); end
        n_checks++; if (so !== 1'b1) begin n_fail++; $display("FAIL word_rd_stall: got %b want 1", so); end
        n_checks++; if (rd !== 32'hdead_beef) begin n_fail++; $display("FAIL word_rd_data: got %h want deadbeef", rd); end
        n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL word_rd_exc: got %b want 0", ex); end
    endtask

    task automatic test_lanes();
        int lat; logic [31:0] rd; logic ex, so, sa;
        xfer(1'b0, 1'b1, 32'hb000_0010, 32'h1122_3344, 2'b11, lat, rd, ex, so, sa);
        xfer(1'b0, 1'b1, 32'hb000_0011, 32'hffff_ff5a, 2'b00, lat, rd, ex, so, sa);
        n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL byte_wr_exc: got %b want 0", ex); end
        xfer(1'b0, 1'b0, 32'hb000_0010, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h1122_5a44) begin n_fail++; $display("FAIL byte_merge: got %h want 11225a44", rd); end
        xfer(1'b0, 1'b0, 32'hb000_0013, 32'h0, 2'b00, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h0000_0011) begin n_fail++; $display("FAIL byte_rd3: got %h want 00000011", rd); end
        xfer(1'b0, 1'b0, 32'hb000_0011, 32'h0, 2'b00, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h0000_005a) begin n_fail++; $display("FAIL byte_rd1: got %h want 0000005a", rd); end
        xfer(1'b0, 1'b0, 32'hb000_0012, 32'h0, 2'b01, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h0000_1122) begin n_fail++; $display("FAIL half_rd2: got %h want 00001122", rd); end
        n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL half_rd2_exc: got %b want 0", ex); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic ex, so, sa;
        xfer(1'b0, 1'b1, 32'hb000_0000, 32'hcafe_f00d, 2'b11, lat, rd, ex, so, sa);
        xfer(1'b0, 1'b1, 32'hb000_0004, 32'h0102_0304, 2'b11, lat, rd, ex, so, sa);
        xfer(1'b0, 1'b1, 32'hb000_0001, 32'h0000_ffff, 2'b01, lat, rd, ex, so, sa);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL half_mis_lat: got %0d want 2", lat); end
        n_checks++; if (ex !== 1'b1) begin n_fail++; $display("FAIL half_mis_exc: got %b want 1", ex); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL half_mis_data: got %h want 0", rd); end
        xfer(1'b0, 1'b1, 32'hb000_0006, 32'hffff_ffff, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (ex !== 1'b1) begin n_fail++; $display("FAIL word_mis_wr_exc: got %b want 1", ex); end
        xfer(1'b0, 1'b0, 32'hb000_0006, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (ex !== 1'b1) begin n_fail++; $display("FAIL word_mis_rd_exc: got %b want 1", ex); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL word_mis_rd_data: got %h want 0", rd); end
        xfer(1'b0, 1'b0, 32'hb000_0000, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'hcafe_f00d) begin n_fail++; $display("FAIL mis_keep0: got %h want cafef00d", rd); end
        xfer(1'b0, 1'b0, 32'hb000_0004, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL mis_keep4: got %h want 01020304", rd); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic ex, so, sa;
        xfer(1'b0, 1'b0, 32'hb001_0000, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL oor_hi_lat: got %0d want 2", lat); end
        n_checks++; if (ex !== 1'b1) begin n_fail++; $display("FAIL oor_hi_exc: got %b want 1", ex); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_hi_data: got %h want 0", rd); end
        xfer(1'b0, 1'b0, 32'hafff_fffc, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (ex !== 1'b1) begin n_fail++; $display("FAIL oor_lo_exc: got %b want 1", ex); end
        xfer(1'b0, 1'b0, 32'hb000_0010, 32'h0, 2'b10, lat, rd, ex, so, sa);
        n_checks++; if (ex !== 1'b1) begin n_fail++; $display("FAIL rsvd_width_exc: got %b want 1", ex); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rsvd_width_data: got %h want 0", rd); end
        xfer(1'b0, 1'b1, 32'hb000_fffc, 32'ha5a5_5a5a, 2'b11, lat, rd, ex, so, sa);
        xfer(1'b0, 1'b0, 32'hb000_fffc, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL top_word_exc: got %b want 0", ex); end
        n_checks++; if (rd !== 32'ha5a5_5a5a) begin n_fail++; $display("FAIL top_word_data: got %h want a5a55a5a", rd); end
    endtask

    task automatic test_abort();
        int lat; int acks; logic [31:0] rd; logic ex, so, sa;
        xfer(1'b0, 1'b1, 32'hb000_0020, 32'h7654_3210, 2'b11, lat, rd, ex, so, sa);
        @(negedge clk);
        sel_q = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        addr = 32'hb000_0020; wdata = 32'h1234_5678; width = 2'b11;
        @(negedge clk);
        stb = 1'b0;
        n_checks++; if (stl_s !== 1'b1) begin n_fail++; $display("FAIL abort_stall: got %b want 1", stl_s); end
        cyc = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack_s) acks++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL abort_acks: got %0d want 0", acks); end
        n_checks++; if (stl_s !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", stl_s); end
        xfer(1'b0, 1'b0, 32'hb000_0020, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h7654_3210) begin n_fail++; $display("FAIL abort_nowrite: got %h want 76543210", rd); end
    endtask

    task automatic test_stalled_strobe();
        int acks; logic [31:0] rd;
        @(negedge clk);
        sel_q = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0;
        addr = 32'hb000_0020; width = 2'b11;
        @(negedge clk);
        addr = 32'hb000_0010;
        acks = 0;
        rd = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_s) begin
                acks++;
                rd = dat_s;
            end
            stb = 1'b0;
        end
        cyc = 1'b0;
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL stall_strobe_acks: got %0d want 1", acks); end
        n_checks++; if (rd !== 32'h7654_3210) begin n_fail++; $display("FAIL stall_strobe_data: got %h want 76543210", rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic ex, so, sa;
        xfer(1'b0, 1'b1, 32'hb000_0030, 32'h3333_3333, 2'b11, lat, rd, ex, so, sa);
        xfer(1'b0, 1'b0, 32'hb000_0030, 32'h0, 2'b11, lat, rd, ex, so, sa);
        @(negedge clk);
        sel_q = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        addr = 32'hb000_0030; wdata = 32'h9999_9999; width = 2'b11;
        @(negedge clk);
        stb = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if ({ack1, stl1, exc1} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctrl: got %b want 000", {ack1, stl1, exc1}); end
        n_checks++; if (dat1 !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", dat1); end
        @(negedge clk);
        cyc = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        xfer(1'b0, 1'b0, 32'hb000_0030, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h3333_3333) begin n_fail++; $display("FAIL midrst_nowrite: got %h want 33333333", rd); end
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] rd; logic ex, so, sa;
        xfer(1'b1, 1'b1, 32'hb000_0040, 32'h0f0e_0d0c, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_wr_lat: got %0d want 1", lat); end
        n_checks++; if (sa !== 1'b0) begin n_fail++; $display("FAIL ws0_stall_drop: got %b want 0", sa); end
        xfer(1'b1, 1'b0, 32'hb000_0040, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_rd_lat: got %0d want 1", lat); end
        n_checks++; if (rd !== 32'h0f0e_0d0c) begin n_fail++; $display("FAIL ws0_rd_data: got %h want 0f0e0d0c", rd); end
        xfer(1'b1, 1'b0, 32'hb000_0042, 32'h0, 2'b01, lat, rd, ex, so, sa);
        n_checks++; if (rd !== 32'h0000_0f0e) begin n_fail++; $display("FAIL ws0_half: got %h want 00000f0e", rd); end
        xfer(1'b1, 1'b0, 32'hb000_0041, 32'h0, 2'b11, lat, rd, ex, so, sa);
        n_checks++; if ({ex, lat == 1} !== 2'b11) begin n_fail++; $display("FAIL ws0_mis: got exc=%b lat=%0d want exc=1 lat=1", ex, lat); end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; sel_q = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = 32'h0; wdata = 32'h0; width = 2'b11;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_word();
        test_lanes();
        test_misaligned();
        test_range();
        test_abort();
        test_stalled_strobe();
        test_reset_mid();
        test_zero_wait();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
